// File: rtl/reg_bank_arb.sv
// rtl/reg_bank_arb.sv - round-robin arbitrated register bank (optional REG_BANK_ARB_LOCK_EN adds a per-requester lock input)
module reg_bank_arb #(
    parameter int NR = 2,
    parameter int RN = 4,
    parameter int dw = 8,
    parameter int AW = 2
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [NR-1:0]      req,
    input  logic [NR-1:0]      we,
    input  logic [NR-1:0]      clr,
    input  logic [NR*AW-1:0]   addr,
    input  logic [NR*dw-1:0]   wdata,
`ifdef REG_BANK_ARB_LOCK_EN
    input  logic [NR-1:0]      lock,
`endif
    output logic [NR-1:0]      gnt,
    output logic [dw-1:0]      rdata,
    output logic               err,
    output logic [RN*dw-1:0]   bank
);

    localparam int IW = (NR > 1) ? $clog2(NR) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   win_q, win_d;
    logic [dw-1:0]   bank_q [RN];

`ifdef REG_BANK_ARB_LOCK_EN
    // While set, win_q is the lock owner and the only eligible requester.
    logic            locked_q, locked_d;
`endif

    logic [NR-1:0]   elig;
    logic            pick_found;
    logic [IW-1:0]   pick_idx;
    logic [IW-1:0]   cand;

    logic [AW-1:0]   acc_addr;
    logic            acc_we;
    logic            acc_clr;
    logic [dw-1:0]   acc_wdata;
    logic            addr_ok;
    logic [dw-1:0]   rd_sel;
    logic            do_write;
    logic [dw-1:0]   wr_val;

    // Requester index successor with wrap at NR-1.
    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] v);
        if (int'(v) == NR - 1) begin
            return '0;
        end
        return v + IW'(1);
    endfunction

    // Eligible requesters: everyone, or only the lock owner while locked.
    always_comb begin
        elig = req;
`ifdef REG_BANK_ARB_LOCK_EN
        if (locked_q) begin
            elig = req & (NR'(1) << win_q);
        end
`endif
    end

    // Round-robin pick: first eligible requester at or above ptr, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = ptr_q;
        for (int k = 0; k < NR; k++) begin
            if (!pick_found && elig[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
            cand = wrap_inc(cand);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: one arbitration cycle, one access cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_found) state_d = ACC;
            ACC:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Decode of the winner's request fields, sampled live during ACC.
    always_comb begin
        acc_addr  = addr[win_q*AW +: AW];
        acc_we    = we[win_q];
        acc_clr   = clr[win_q];
        acc_wdata = wdata[win_q*dw +: dw];
        addr_ok   = ({1'b0, acc_addr} < (AW+1)'(RN));
        rd_sel    = '0;
        for (int r = 0; r < RN; r++) begin
            if (acc_addr == AW'(r)) begin
                rd_sel = bank_q[r];
            end
        end
        do_write  = (state_q == ACC) && acc_we && addr_ok;
        wr_val    = acc_clr ? '0 : acc_wdata;
    end

    // FSM outputs: strobe, read data and error exist only during ACC.
    always_comb begin
        gnt   = '0;
        rdata = '0;
        err   = 1'b0;
        if (state_q == ACC) begin
            gnt = NR'(1) << win_q;
            err = !addr_ok;
            if (!acc_we && addr_ok) begin
                rdata = rd_sel;
            end
        end
    end

    // Winner latch and pointer update; a locked completion keeps ptr in place.
    always_comb begin
        win_d = win_q;
        ptr_d = ptr_q;
`ifdef REG_BANK_ARB_LOCK_EN
        locked_d = locked_q;
`endif
        if (state_q == IDLE && pick_found) begin
            win_d = pick_idx;
        end
        if (state_q == ACC) begin
`ifdef REG_BANK_ARB_LOCK_EN
            locked_d = lock[win_q];
            if (!lock[win_q]) begin
                ptr_d = wrap_inc(win_q);
            end
`else
            ptr_d = wrap_inc(win_q);
`endif
        end
    end

    // Arbitration registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            win_q <= '0;
            ptr_q <= '0;
`ifdef REG_BANK_ARB_LOCK_EN
            locked_q <= 1'b0;
`endif
        end else begin
            win_q <= win_d;
            ptr_q <= ptr_d;
`ifdef REG_BANK_ARB_LOCK_EN
            locked_q <= locked_d;
`endif
        end
    end

    // Bank storage: written at the end of an in-range write access.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int r = 0; r < RN; r++) begin
                bank_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < RN; r++) begin
                if (do_write && acc_addr == AW'(r)) begin
                    bank_q[r] <= wr_val;
                end
            end
        end
    end

    // Flatten the bank for the live-contents output.
    always_comb begin
        bank = '0;
        for (int r = 0; r < RN; r++) begin
            bank[r*dw +: dw] = bank_q[r];
        end
    end

endmodule

// File: tb/tb_reg_bank_arb.sv
// tb/tb_reg_bank_arb.sv - directed self-checking bench for reg_bank_arb
module tb_reg_bank_arb;

    logic        clk = 1'b0;
    logic        rstn;
    logic [1:0]  req, we, clr;
    logic [3:0]  addr;
    logic [15:0] wdata;
`ifdef REG_BANK_ARB_LOCK_EN
    logic [1:0]  lock;
`endif

    logic [1:0]  gnt_a, gnt_b;
    logic [7:0]  rdata_a, rdata_b;
    logic        err_a, err_b;
    logic [31:0] bank_a;
    logic [23:0] bank_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    reg_bank_arb #(.NR(2), .RN(4), .dw(8), .AW(2)) u_dut (
        .clk(clk), .rstn(rstn), .req(req), .we(we), .clr(clr),
        .addr(addr), .wdata(wdata),
`ifdef REG_BANK_ARB_LOCK_EN
        .lock(lock),
`endif
        .gnt(gnt_a), .rdata(rdata_a), .err(err_a), .bank(bank_a)
    );

    reg_bank_arb #(.NR(2), .RN(3), .dw(8), .AW(2)) u_dut_rn3 (
        .clk(clk), .rstn(rstn), .req(req), .we(we), .clr(clr),
        .addr(addr), .wdata(wdata),
`ifdef REG_BANK_ARB_LOCK_EN
        .lock(lock),
`endif
        .gnt(gnt_b), .rdata(rdata_b), .err(err_b), .bank(bank_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req = '0; we = '0; clr = '0; addr = '0; wdata = '0;
`ifdef REG_BANK_ARB_LOCK_EN
        lock = '0;
`endif
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    // One uncontended access by requester i; checks strobe, read data, error.
    task automatic single(input string tag, input int i, input logic w, input logic c,
                          input logic [1:0] a, input logic [7:0] d, input logic [7:0] exp_rd);
        idle_inputs();
        req[i] = 1'b1;
        we[i]  = w;
        clr[i] = c;
        addr[i*2 +: 2]  = a;
        wdata[i*8 +: 8] = d;
        tick();
        chk({tag, "_gnt"}, 32'(gnt_a), 32'(2'b01 << i));
        chk({tag, "_rdata"}, 32'(rdata_a), 32'(exp_rd));
        chk({tag, "_err"}, 32'(err_a), 32'd0);
        tick();
        chk({tag, "_gnt_off"}, 32'(gnt_a), 32'd0);
        idle_inputs();
    endtask

    initial begin
        rstn = 1'b0;
        idle_inputs();
        #2;
        chk("rst_gnt", 32'(gnt_a), 32'd0);
        chk("rst_rdata", 32'(rdata_a), 32'd0);
        chk("rst_err", 32'(err_a), 32'd0);
        chk("rst_bank", bank_a, 32'd0);
        do_reset();

        // Single write, uncontended: bank[2] = A5.
        single("w_a5", 0, 1'b1, 1'b0, 2'd2, 8'hA5, 8'h00);
        chk("w_a5_bank", bank_a, 32'h00A5_0000);

        // Contention from reset: 0 then 1, alternating, then 0 again.
        do_reset();
        req = 2'b11; we = 2'b11; addr = 4'b0101; wdata = 16'h2211;
        tick();
        chk("rr1_gnt", 32'(gnt_a), 32'h1);
        tick();
        chk("rr1_off", 32'(gnt_a), 32'd0);
        chk("rr1_bank", bank_a, 32'h0000_1100);
        tick();
        chk("rr2_gnt", 32'(gnt_a), 32'h2);
        tick();
        chk("rr2_bank", bank_a, 32'h0000_2200);
        tick();
        chk("rr3_gnt", 32'(gnt_a), 32'h1);
        idle_inputs();
        req = 2'b01; we = 2'b01; addr = 4'b0101; wdata = 16'h2211;
        tick();
        idle_inputs();
        chk("rr3_bank", bank_a, 32'h0000_1100);

        // Clear write overrides data, then read back; clr ignored on reads.
        single("w_7f", 0, 1'b1, 1'b0, 2'd3, 8'h7F, 8'h00);
        chk("w_7f_bank", bank_a, 32'h7F00_1100);
        single("clr3", 1, 1'b1, 1'b1, 2'd3, 8'hFF, 8'h00);
        chk("clr3_bank", bank_a, 32'h0000_1100);
        single("rd3", 0, 1'b0, 1'b1, 2'd3, 8'h00, 8'h00);
        single("rd1", 1, 1'b0, 1'b0, 2'd1, 8'h00, 8'h11);
        chk("rd1_bank", bank_a, 32'h0000_1100);

        // Request dropped before selection is not served.
        req = 2'b10;
        #3;
        req = 2'b00;
        tick();
        chk("drop_gnt", 32'(gnt_a), 32'd0);

        // Out-of-range address on the RN=3 instance.
        do_reset();
        req = 2'b01; we = 2'b01; addr = 4'd3; wdata = 16'h005A;
        tick();
        chk("oor_w_gnt", 32'(gnt_b), 32'h1);
        chk("oor_w_err", 32'(err_b), 32'd1);
        chk("inr_w_err", 32'(err_a), 32'd0);
        tick();
        idle_inputs();
        chk("oor_w_bank", 32'(bank_b), 32'd0);
        chk("inr_w_bank", bank_a, 32'h5A00_0000);
        req = 2'b01; we = 2'b00; addr = 4'd3;
        tick();
        chk("oor_r_gnt", 32'(gnt_b), 32'h1);
        chk("oor_r_err", 32'(err_b), 32'd1);
        chk("oor_r_rdata", 32'(rdata_b), 32'd0);
        chk("inr_r_rdata", 32'(rdata_a), 32'h5A);
        tick();
        idle_inputs();
        chk("oor_off_err", 32'(err_b), 32'd0);

        // Reset in the middle of an access aborts it.
        do_reset();
        req = 2'b01; we = 2'b01; addr = 4'd0; wdata = 16'h00FF;
        tick();
        chk("abort_pre_gnt", 32'(gnt_a), 32'h1);
        #2;
        rstn = 1'b0;
        #1;
        chk("abort_gnt", 32'(gnt_a), 32'd0);
        @(posedge clk);
        #1;
        chk("abort_bank", bank_a, 32'd0);
        idle_inputs();
        @(negedge clk);
        rstn = 1'b1;
        req = 2'b11;
        tick();
        chk("abort_ptr0", 32'(gnt_a), 32'h1);
        tick();
        idle_inputs();
        chk("abort_bank2", bank_a, 32'd0);

`ifdef REG_BANK_ARB_LOCK_EN
        // Locked requester 0 keeps the bank while requester 1 waits.
        do_reset();
        req = 2'b11; we = 2'b11; addr = 4'b0100; lock = 2'b01;
        for (int n = 0; n < 3; n++) begin
            wdata = {8'h33, 8'(8'h40 + n)};
            tick();
            chk("lock_gnt", 32'(gnt_a), 32'h1);
            tick();
            chk("lock_off", 32'(gnt_a), 32'd0);
        end
        lock = 2'b00;
        wdata = 16'h3350;
        tick();
        chk("unlock_gnt", 32'(gnt_a), 32'h1);
        tick();
        tick();
        chk("after_unlock_gnt", 32'(gnt_a), 32'h2);
        tick();
        idle_inputs();
        chk("lock_bank", bank_a, 32'h0000_3350);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
